// File: rtl/pmem_line_arbiter.sv
// Round-robin arbiter sharing one physical-memory line port between the I-cache and D-cache.
// One line transaction in flight at a time; response and read data go back to the granted cache only.
//
//   state   | meaning
//   IDLE    | no transaction; all outputs low; picks next requester
//   SERVE_I | I-cache line read driven onto pmem until pmem_resp
//   SERVE_D | D-cache fill or writeback driven onto pmem until pmem_resp
module pmem_line_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    parameter int MAX_WAIT   = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  icache_read,
    input  logic [ADDR_WIDTH-1:0] icache_address,
    output logic [LINE_WIDTH-1:0] icache_rdata,
    output logic                  icache_resp,
    input  logic                  dcache_read,
    input  logic                  dcache_write,
    input  logic [ADDR_WIDTH-1:0] dcache_address,
    input  logic [LINE_WIDTH-1:0] dcache_wdata,
    output logic [LINE_WIDTH-1:0] dcache_rdata,
    output logic                  dcache_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic                  timeout
);

    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);
    localparam logic          GRANT_I  = 1'b0;
    localparam logic          GRANT_D  = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          is_write_q, is_write_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          timeout_q, timeout_d;
    logic          req_i, req_d;

    assign req_i   = icache_read;
    assign req_d   = dcache_read | dcache_write;
    assign timeout = timeout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            is_write_q   <= 1'b0;
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            is_write_q   <= is_write_d;
            wait_cnt_q   <= wait_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        is_write_d   = is_write_q;
        wait_cnt_d   = wait_cnt_q;
        timeout_d    = timeout_q;
        icache_rdata = '0;
        icache_resp  = 1'b0;
        dcache_rdata = '0;
        dcache_resp  = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;

        unique case (state_q)
            IDLE: begin
                // On contention the side that did not win last time gets the port.
                if (req_i && (!req_d || (last_grant_q == GRANT_D))) begin
                    state_d      = SERVE_I;
                    last_grant_d = GRANT_I;
                    wait_cnt_d   = '0;
                end else if (req_d) begin
                    state_d      = SERVE_D;
                    last_grant_d = GRANT_D;
                    is_write_d   = dcache_write;
                    wait_cnt_d   = '0;
                end
            end
            SERVE_I: begin
                pmem_read    = 1'b1;
                pmem_address = icache_address;
                if (pmem_resp) begin
                    icache_resp  = 1'b1;
                    icache_rdata = pmem_rdata;
                    state_d      = IDLE;
                end else if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            SERVE_D: begin
                pmem_read    = ~is_write_q;
                pmem_write   = is_write_q;
                pmem_address = dcache_address;
                pmem_wdata   = dcache_wdata;
                if (pmem_resp) begin
                    dcache_resp  = 1'b1;
                    dcache_rdata = pmem_rdata;
                    state_d      = IDLE;
                end else if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A zero limit disables the debug flag entirely.
        if ((MAX_WAIT > 0) && (state_q != IDLE) && (wait_cnt_d == WAIT_MAX)) begin
            timeout_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_pmem_line_arbiter.sv
// Directed bench for pmem_line_arbiter: single transactions, alternation, reset abort,
// timeout flag and stray pmem responses, all with hand-computed expectations.
module tb_pmem_line_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          icache_read = 1'b0;
    logic [AW-1:0] icache_address = '0;
    logic [LW-1:0] icache_rdata;
    logic          icache_resp;
    logic          dcache_read = 1'b0;
    logic          dcache_write = 1'b0;
    logic [AW-1:0] dcache_address = '0;
    logic [LW-1:0] dcache_wdata = '0;
    logic [LW-1:0] dcache_rdata;
    logic          dcache_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;
    logic          timeout;

    int vec_cnt = 0;
    int err_cnt = 0;

    localparam logic [LW-1:0] D0 = {8{32'hD0D0_0001}};
    localparam logic [LW-1:0] D1 = {8{32'hA5A5_1234}};
    localparam logic [LW-1:0] D2 = {8{32'h0BAD_F00D}};
    localparam logic [LW-1:0] W  = {8{32'hCAFE_0042}};

    always #5 clk = ~clk;

    pmem_line_arbiter #(
        .ADDR_WIDTH(AW),
        .LINE_WIDTH(LW),
        .MAX_WAIT  (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .icache_read   (icache_read),
        .icache_address(icache_address),
        .icache_rdata  (icache_rdata),
        .icache_resp   (icache_resp),
        .dcache_read   (dcache_read),
        .dcache_write  (dcache_write),
        .dcache_address(dcache_address),
        .dcache_wdata  (dcache_wdata),
        .dcache_rdata  (dcache_rdata),
        .dcache_resp   (dcache_resp),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp),
        .timeout       (timeout)
    );

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        vec_cnt++;
        assert (obs === exp)
        else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        check({tag, ".pmem_read"},    LW'(pmem_read),    '0);
        check({tag, ".pmem_write"},   LW'(pmem_write),   '0);
        check({tag, ".pmem_address"}, LW'(pmem_address), '0);
        check({tag, ".pmem_wdata"},   pmem_wdata,        '0);
        check({tag, ".icache_resp"},  LW'(icache_resp),  '0);
        check({tag, ".dcache_resp"},  LW'(dcache_resp),  '0);
        check({tag, ".icache_rdata"}, icache_rdata,      '0);
        check({tag, ".dcache_rdata"}, dcache_rdata,      '0);
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        icache_read  = 1'b0;
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
        pmem_resp    = 1'b0;
        repeat (2) nxt();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        // ---- reset state
        icache_address = 32'h0000_0060;
        dcache_address = 32'h0000_01E0;
        dcache_wdata   = W;
        pmem_rdata     = D1;
        #2;
        all_zero("in_reset");
        check("in_reset.timeout", LW'(timeout), '0);
        do_reset();
        all_zero("after_reset");

        // ---- 1: icache read, response 5 cycles after strobe
        nxt();
        icache_read    = 1'b1;
        icache_address = 32'h0000_0060;
        #1;
        check("t1.cycle_t_read", LW'(pmem_read), '0);
        nxt();
        check("t1.strobe_t1", LW'(pmem_read), 1);
        check("t1.write", LW'(pmem_write), 0);
        check("t1.addr", LW'(pmem_address), LW'(32'h60));
        repeat (4) nxt();
        check("t1.no_early_resp", LW'(icache_resp), 0);
        nxt();
        pmem_resp  = 1'b1;
        pmem_rdata = D0;
        #1;
        check("t1.icache_resp", LW'(icache_resp), 1);
        check("t1.icache_rdata", icache_rdata, D0);
        check("t1.dcache_resp", LW'(dcache_resp), 0);
        check("t1.dcache_rdata", dcache_rdata, '0);
        nxt();
        pmem_resp   = 1'b0;
        icache_read = 1'b0;
        #1;
        all_zero("t1.idle_after");
        check("t1.timeout", LW'(timeout), 0);

        // ---- 2: dcache writeback
        nxt();
        dcache_write   = 1'b1;
        dcache_address = 32'h0000_01E0;
        dcache_wdata   = W;
        nxt();
        check("t2.pmem_write", LW'(pmem_write), 1);
        check("t2.pmem_read", LW'(pmem_read), 0);
        check("t2.pmem_wdata", pmem_wdata, W);
        check("t2.addr", LW'(pmem_address), LW'(32'h1E0));
        nxt();
        check("t2.hold_write", LW'(pmem_write), 1);
        nxt();
        pmem_resp  = 1'b1;
        pmem_rdata = D2;
        #1;
        check("t2.dcache_resp", LW'(dcache_resp), 1);
        check("t2.icache_resp", LW'(icache_resp), 0);
        check("t2.icache_rdata", icache_rdata, '0);
        nxt();
        pmem_resp    = 1'b0;
        dcache_write = 1'b0;
        #1;
        all_zero("t2.idle_after");

        // ---- 3: contention after reset -> D, then I, then D again
        do_reset();
        dcache_address = 32'h0000_0100;
        icache_address = 32'h0000_0040;
        icache_read    = 1'b1;
        dcache_read    = 1'b1;
        nxt();
        check("t3.first_addr", LW'(pmem_address), LW'(32'h100));
        check("t3.first_read", LW'(pmem_read), 1);
        pmem_resp = 1'b1;
        pmem_rdata = D1;
        #1;
        check("t3.first_dresp", LW'(dcache_resp), 1);
        check("t3.first_iresp", LW'(icache_resp), 0);
        nxt();
        pmem_resp   = 1'b0;
        dcache_read = 1'b0;
        #1;
        check("t3.gap_idle", LW'(pmem_read), 0);
        nxt();
        check("t3.second_addr", LW'(pmem_address), LW'(32'h40));
        pmem_resp = 1'b1;
        #1;
        check("t3.second_iresp", LW'(icache_resp), 1);
        check("t3.second_dresp", LW'(dcache_resp), 0);
        nxt();
        pmem_resp   = 1'b0;
        icache_read = 1'b0;
        nxt();
        icache_read = 1'b1;
        dcache_read = 1'b1;
        nxt();
        check("t3.third_addr", LW'(pmem_address), LW'(32'h100));
        pmem_resp = 1'b1;
        #1;
        check("t3.third_dresp", LW'(dcache_resp), 1);
        nxt();
        pmem_resp   = 1'b0;
        icache_read = 1'b0;
        dcache_read = 1'b0;

        // ---- 4: reset during SERVE_D
        nxt();
        dcache_read    = 1'b1;
        dcache_address = 32'h0000_0200;
        nxt();
        check("t4.serving", LW'(pmem_read), 1);
        nxt();
        rst = 1'b0;
        #1;
        all_zero("t4.rst_async");
        nxt();
        pmem_resp = 1'b1;
        #1;
        check("t4.no_dresp", LW'(dcache_resp), 0);
        nxt();
        pmem_resp   = 1'b0;
        dcache_read = 1'b0;
        rst         = 1'b1;
        #1;
        all_zero("t4.idle_after");

        // ---- 6: stray pmem_resp in IDLE and in SERVE_I
        nxt();
        pmem_resp = 1'b1;
        #1;
        check("t6.idle_iresp", LW'(icache_resp), 0);
        check("t6.idle_dresp", LW'(dcache_resp), 0);
        nxt();
        pmem_resp = 1'b0;
        #1;
        check("t6.still_idle", LW'(pmem_read), 0);
        dcache_read = 1'b1;
        nxt();
        pmem_resp = 1'b1;
        #1;
        check("t6.d_first", LW'(dcache_resp), 1);
        nxt();
        pmem_resp   = 1'b0;
        dcache_read = 1'b0;
        nxt();
        icache_read = 1'b1;
        dcache_read = 1'b1;
        nxt();
        check("t6.i_granted", LW'(pmem_address), LW'(32'h40));
        pmem_resp  = 1'b1;
        pmem_rdata = D2;
        #1;
        check("t6.serve_i_iresp", LW'(icache_resp), 1);
        check("t6.serve_i_dresp", LW'(dcache_resp), 0);
        check("t6.serve_i_drdata", dcache_rdata, '0);
        nxt();
        pmem_resp   = 1'b0;
        icache_read = 1'b0;
        dcache_read = 1'b0;

        // ---- 5: pmem never responds -> timeout after 8 SERVE cycles
        nxt();
        check("t5.pre_timeout", LW'(timeout), 0);
        icache_read = 1'b1;
        nxt();
        repeat (7) nxt();
        check("t5.timeout_at7", LW'(timeout), 0);
        nxt();
        check("t5.timeout_at8", LW'(timeout), 1);
        check("t5.read_held", LW'(pmem_read), 1);
        repeat (5) nxt();
        check("t5.read_held_late", LW'(pmem_read), 1);
        pmem_resp = 1'b1;
        #1;
        check("t5.late_iresp", LW'(icache_resp), 1);
        nxt();
        pmem_resp   = 1'b0;
        icache_read = 1'b0;
        repeat (2) nxt();
        check("t5.sticky", LW'(timeout), 1);
        do_reset();
        check("t5.cleared", LW'(timeout), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
